alu_op_issue_decoder: RTL and testbench
=======================================

Name: alu_op_issue_decoder

Overview:
- Consumer side of the ALU opcode encoding.
- Accepts packed instruction words from fetch over a valid/ready handshake and decodes the 2-bit opcode field into op_mne (ADDU/SUBU/AND/XOR), plus destination/source register indices and a write-back flag.
- Buffers up to two decoded ops and issues them to the ALU stage over a second valid/ready handshake.
- Sits between the fetch stage and the ALU.

Parameters:
- REG_ADDR_W, 3, register-index width. Instruction width is derived as INSTR_W = 2*REG_ADDR_W + 3 (9 at default).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- flush  in  1  synchronous discard of all buffered ops.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decoder can accept.
- in_instr  in  INSTR_W  packed instruction: [INSTR_W-1:INSTR_W-2]=op, next REG_ADDR_W bits=rd, next REG_ADDR_W bits=rs, [0]=wb.
- out_valid  out  1  decoded op available.
- out_ready  in  1  ALU accepts.
- out_op  out  2 (op_mne)  decoded opcode.
- out_rd  out  REG_ADDR_W  destination index.
- out_rs  out  REG_ADDR_W  source index.
- out_wb  out  1  write-back enable.
- issued_cnt  out  16  count of ops issued since reset.

Behaviour:
- Reset (async, rst_n=0):
  - occupancy=0, in_ready=0 while rst_n low, out_valid=0.
  - out_op=ADDU, out_rd=0, out_rs=0, out_wb=0, issued_cnt=0.
  - Buffer contents are discarded; an op mid-handshake is lost.
- Handshakes:
  - Accept when in_valid & in_ready at a rising edge.
  - Issue when out_valid & out_ready.
  - out_* fields stay stable while out_valid=1 and out_ready=0.
- Occupancy state machine, registered:
  - EMPTY(0) -> ONE on accept.
  - ONE -> FULL on accept without issue.
  - ONE -> EMPTY on issue without accept.
  - ONE -> ONE on simultaneous accept+issue.
  - FULL -> ONE on issue.
  - FULL: in_ready=0, so no accept is possible.
- Output decode: in_ready = (occupancy != FULL) & rst_n. out_valid = (occupancy != EMPTY).
- Ordering: strict FIFO. Head entry drives out_*.
- Latency (base): accept at edge N -> out_valid high after edge N (one cycle). No combinational path from in_* to out_*, or from out_ready to in_ready.
- Decode: opcode field maps directly onto op_mne. All four encodings are legal. No illegal-op handling.
- flush:
  - Sampled at the edge; has priority over accept and issue in the same cycle.
  - Occupancy -> EMPTY; the concurrent accept and issue are both ignored.
  - issued_cnt is not incremented.
- issued_cnt: +1 per issue handshake; wraps 0xFFFF -> 0x0000.
- Write pointer and read pointer are 1 bit each and wrap modulo 2.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined:
  - When occupancy=EMPTY and in_valid=1, out_valid is driven combinationally, with out_* decoded directly from in_instr.
  - If out_ready=1 in that cycle, the op issues with zero latency: not written to the buffer, issued_cnt increments.
  - If out_ready=0, the op is written to the buffer as normal.
- Undefined: one-cycle latency as in the base behaviour; no in->out combinational path.

Decomposition:
- Shared package:
  - op_mne is reused.
  - Add field-position constants: OP_MSB/OP_LSB relative to INSTR_W.
  - Add a packed struct typedef alu_issue_t {op_mne op; rd; rs; wb}, with rd/rs sized by a package-level REG_ADDR_W constant default 3.
- Sub-module: alu_issue_fifo, a 2-entry FIFO of alu_issue_t with pointers, occupancy, and full/empty flags. The top handles decode, flush gating, the counter, and the bypass.

Test Plan:
- Reset then single op: in_instr=9'b01_011_101_1, out_ready=1 -> next cycle out_op=SUBU, out_rd=3, out_rs=5, out_wb=1 for one cycle; issued_cnt=1.
- Backpressure fill: out_ready=0, push XOR(9'b11_001_010_0) then AND(9'b10_111_000_1) -> in_ready=0 after the second accept; third in_valid is not accepted; out_* hold XOR. Raise out_ready -> XOR then AND issue in order; in_ready returns to 1.
- Simultaneous accept+issue at ONE: streaming ADDU ops with out_ready=1 every cycle -> occupancy stays ONE, throughput 1 op/cycle; issued_cnt=10 after 10 issues.
- Flush with a concurrent handshake at FULL: flush=1 with out_ready=1 -> next cycle out_valid=0, issued_cnt unchanged, in_ready=1.
- Async reset mid-stream: rst_n low between edges while FULL -> out_valid=0 and issued_cnt=0 immediately, in_ready=0 until rst_n rises.
- Counter wrap (force/preload 16'hFFFF) then one issue -> issued_cnt=0. With ALU_ISSUE_BYPASS_EN, empty + in_valid + out_ready -> out_valid and the decoded op appear in the same cycle.

Source files
------------

// File: rtl/alu_op_issue_decoder_pkg.sv
// Shared types for the ALU opcode issue path: opcode mnemonics, instruction
// field positions, the decoded-op record, and the buffer occupancy states.
package alu_op_issue_decoder_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int INSTR_W    = 2 * REG_ADDR_W + 3;

  // Instruction layout, MSB first: op | rd | rs | wb
  localparam int OP_MSB = INSTR_W - 1;
  localparam int OP_LSB = INSTR_W - 2;
  localparam int RD_MSB = OP_LSB - 1;
  localparam int RD_LSB = RD_MSB - REG_ADDR_W + 1;
  localparam int RS_MSB = RD_LSB - 1;
  localparam int RS_LSB = RS_MSB - REG_ADDR_W + 1;
  localparam int WB_BIT = 0;

  typedef enum logic [1:0] {
    ADDU = 2'd0,
    SUBU = 2'd1,
    AND  = 2'd2,
    XOR  = 2'd3
  } op_mne;

  typedef struct packed {
    op_mne                 op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic                  wb;
  } alu_issue_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Every opcode encoding is legal, so the op field is taken as-is.
  function automatic alu_issue_t decode_instr(input logic [INSTR_W-1:0] instr);
    alu_issue_t d;
    d.op = op_mne'(instr[OP_MSB:OP_LSB]);
    d.rd = instr[RD_MSB:RD_LSB];
    d.rs = instr[RS_MSB:RS_LSB];
    d.wb = instr[WB_BIT];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Two-entry FIFO of decoded ALU ops. 1-bit read/write pointers wrap modulo 2;
// the occupancy state supplies the empty/full flags. clr empties the buffer
// and takes priority over push and pop in the same cycle.
module alu_issue_fifo
  import alu_op_issue_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  alu_issue_t wdata,
  output alu_issue_t rdata,
  output logic       empty,
  output logic       full
);

  occ_e       occ_q, occ_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  alu_issue_t mem_q [2];
  alu_issue_t mem_d [2];

  // Next-state for pointers, storage and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr) begin
      occ_d    = OCC_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case (occ_q)
        OCC_EMPTY: if (push) occ_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ_d = OCC_FULL;
          else if (pop && !push) occ_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ_d = OCC_ONE;
        default:   occ_d = OCC_EMPTY;
      endcase
    end
  end

  // State registers; storage is reset too so the head reads as ADDU/0/0/0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      occ_q    <= OCC_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      // NOTE: the two entries are reset because the head entry drives visible outputs.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (occ_q == OCC_EMPTY);
  assign full  = (occ_q == OCC_FULL);

endmodule

// File: rtl/alu_op_issue_decoder.sv
// ALU op issue decoder: accepts instruction words from fetch, decodes the
// opcode/register fields, buffers up to two ops and issues them to the ALU
// in order. Optional zero-latency bypass when empty: define ALU_ISSUE_BYPASS_EN.
module alu_op_issue_decoder #(
  parameter  int REG_ADDR_W = alu_op_issue_decoder_pkg::REG_ADDR_W,
  localparam int INSTR_W    = 2 * REG_ADDR_W + 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INSTR_W-1:0]              in_instr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output alu_op_issue_decoder_pkg::op_mne out_op,
  output logic [REG_ADDR_W-1:0]           out_rd,
  output logic [REG_ADDR_W-1:0]           out_rs,
  output logic                            out_wb,
  output logic [15:0]                     issued_cnt
);

  import alu_op_issue_decoder_pkg::*;

  alu_issue_t  dec;
  alu_issue_t  head;
  alu_issue_t  fifo_rdata;
  logic        fifo_empty;
  logic        fifo_full;
  logic        accept;
  logic        issue;
  logic        push;
  logic        pop;
  logic [15:0] issued_cnt_q, issued_cnt_d;

  assign dec      = decode_instr(in_instr);
  assign in_ready = !fifo_full && rst_n;
  // flush wins over both handshakes in the same cycle.
  assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_ISSUE_BYPASS_EN
  // Empty buffer: present the incoming op directly; store it only if the ALU stalls.
  assign out_valid = !fifo_empty || (in_valid && rst_n);
  assign head      = fifo_empty ? dec : fifo_rdata;
  assign issue     = out_valid && out_ready && !flush;
  assign push      = accept && !(fifo_empty && out_ready);
  assign pop       = issue && !fifo_empty;
`else
  assign out_valid = !fifo_empty;
  assign head      = fifo_rdata;
  assign issue     = out_valid && out_ready && !flush;
  assign push      = accept;
  assign pop       = issue;
`endif

  alu_issue_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Issue counter: one per issue handshake, wraps naturally at 16 bits.
  always_comb begin
    issued_cnt_d = issued_cnt_q;
    if (issue) issued_cnt_d = issued_cnt_q + 16'd1;
  end

  // Issue counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issued_cnt_q <= 16'd0;
    else        issued_cnt_q <= issued_cnt_d;
  end

  assign out_op     = head.op;
  assign out_rd     = head.rd;
  assign out_rs     = head.rs;
  assign out_wb     = head.wb;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_alu_op_issue_decoder.sv
// Self-checking bench for alu_op_issue_decoder: a negedge scoreboard checks
// every issued op against accepted instructions in FIFO order, a vector table
// drives a streaming run, and directed sequences cover backpressure, flush,
// async reset and counter wrap. Bypass expectations follow ALU_ISSUE_BYPASS_EN.
module tb_alu_op_issue_decoder;
  import alu_op_issue_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_instr;
  logic        out_valid;
  logic        out_ready;
  op_mne       out_op;
  logic [2:0]  out_rd;
  logic [2:0]  out_rs;
  logic        out_wb;
  logic [15:0] issued_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] sb_q[$];

  typedef struct {
    logic [8:0] instr;
    op_mne      op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       wb;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tab[NVEC];

  alu_op_issue_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_wb     (out_wb),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input op_mne op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic wb);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_fields"}, 32'({out_op, out_rd, out_rs, out_wb}), 32'({op, rd, rs, wb}));
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, where inputs and outputs are settled.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
    end else if (flush) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(in_instr);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_issue_without_accept", 32'(sb_q.size()), 32'd1);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          check("sb_issue_order", 32'({out_op, out_rd, out_rs, out_wb}), 32'(e));
        end
      end
    end
  end

  initial begin
    tab[0] = '{9'b00_000_001_1, ADDU, 3'd0, 3'd1, 1'b1};
    tab[1] = '{9'b00_010_011_0, ADDU, 3'd2, 3'd3, 1'b0};
    tab[2] = '{9'b01_100_101_1, SUBU, 3'd4, 3'd5, 1'b1};
    tab[3] = '{9'b10_110_111_0, AND,  3'd6, 3'd7, 1'b0};
    tab[4] = '{9'b11_111_000_1, XOR,  3'd7, 3'd0, 1'b1};
    tab[5] = '{9'b00_001_001_1, ADDU, 3'd1, 3'd1, 1'b1};
    tab[6] = '{9'b01_000_111_0, SUBU, 3'd0, 3'd7, 1'b0};
    tab[7] = '{9'b10_011_100_1, AND,  3'd3, 3'd4, 1'b1};
    tab[8] = '{9'b11_101_010_0, XOR,  3'd5, 3'd2, 1'b0};
    tab[9] = '{9'b00_111_111_1, ADDU, 3'd7, 3'd7, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fields", 32'({out_op, out_rd, out_rs, out_wb}), 32'd0);
    check("rst_cnt", 32'(issued_cnt), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Single op
    cyc();
    in_valid = 1'b1; in_instr = 9'b01_011_101_1; out_ready = 1'b1;
    #1;
`ifdef ALU_ISSUE_BYPASS_EN
    check_out("single_bypass", SUBU, 3'd3, 3'd5, 1'b1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("single_done_valid", 32'(out_valid), 32'd0);
    check("single_cnt", 32'(issued_cnt), 32'd1);
`else
    check("single_no_comb_path", 32'(out_valid), 32'd0);
    cyc();
    in_valid = 1'b0;
    #1;
    check_out("single", SUBU, 3'd3, 3'd5, 1'b1);
    cyc(); #1;
    check("single_done_valid", 32'(out_valid), 32'd0);
    check("single_cnt", 32'(issued_cnt), 32'd1);
`endif

    // Backpressure fill
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b11_001_010_0;
    cyc();
    in_instr = 9'b10_111_000_1;
    cyc();
    in_instr = 9'b00_110_110_1;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check_out("bp_head_xor", XOR, 3'd1, 3'd2, 1'b0);
    cyc(); cyc(); #1;
    check("bp_still_full", 32'(in_ready), 32'd0);
    check_out("bp_hold_xor", XOR, 3'd1, 3'd2, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); #1;
    check_out("bp_head_and", AND, 3'd7, 3'd0, 1'b1);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    cyc(); #1;
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_cnt", 32'(issued_cnt), 32'd3);

    // Table-driven streaming: occupancy holds at ONE (or EMPTY with bypass)
    for (int i = 0; i <= NVEC; i++) begin
      cyc();
      in_valid = (i < NVEC);
      if (i < NVEC) in_instr = tab[i].instr;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_ISSUE_BYPASS_EN
      if (i < NVEC) check_out("stream", tab[i].op, tab[i].rd, tab[i].rs, tab[i].wb);
`else
      if (i > 0) check_out("stream", tab[i-1].op, tab[i-1].rd, tab[i-1].rs, tab[i-1].wb);
`endif
    end
    cyc(); #1;
    check("stream_drained", 32'(out_valid), 32'd0);
    check("stream_cnt", 32'(issued_cnt), 32'd13);

    // Flush at FULL with concurrent handshakes
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 9'b01_001_001_1;
    cyc();
    in_instr = 9'b10_010_010_0;
    cyc(); #1;
    check("flush_pre_full", 32'(in_ready), 32'd0);
    flush = 1'b1; out_ready = 1'b1; in_instr = 9'b11_100_100_1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_full_in_ready", 32'(in_ready), 32'd1);
    check("flush_full_cnt", 32'(issued_cnt), 32'd13);

    // Flush at ONE with simultaneous accept and issue
    cyc();
    in_valid = 1'b1; in_instr = 9'b11_011_011_1;
    cyc();
    flush = 1'b1; out_ready = 1'b1; in_instr = 9'b00_100_100_0;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_one_valid", 32'(out_valid), 32'd0);
    check("flush_one_cnt", 32'(issued_cnt), 32'd13);

    // Async reset while FULL
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b1; in_instr = 9'b01_101_110_1;
    cyc();
    in_instr = 9'b10_001_011_0;
    cyc();
    in_valid = 1'b0;
    #1;
    check("areset_pre_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_cnt", 32'(issued_cnt), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd0);
    cyc(); #1;
    check("areset_held_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("areset_release_in_ready", 32'(in_ready), 32'd1);
    check("areset_release_valid", 32'(out_valid), 32'd0);

    // Counter wrap: 65535 streamed ADDU ops, then one more
    cyc();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 9'b00_001_010_1;
    for (int i = 0; i < 65535; i++) cyc();
    in_valid = 1'b0;
    cyc(); cyc(); #1;
    check("wrap_at_ffff", 32'(issued_cnt), 32'h0000_ffff);
    in_valid = 1'b1; in_instr = 9'b11_110_001_0;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc(); #1;
    check("wrap_to_zero", 32'(issued_cnt), 32'd0);
    check("wrap_drained", 32'(out_valid), 32'd0);

    check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
